// File: rtl/branch_pred_tracker.sv
// Tracks in-flight branch predictions in a circular FIFO and reports predictor
// updates and mispredicts on resolve. Define BPRED_STATS_EN to add the statistics counters.
module branch_pred_tracker #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_pc,
    input  logic [WIDTH-1:0]           push_target,
    input  logic                       push_taken,
    input  logic                       resolve,
    input  logic                       resolve_taken,
    input  logic [WIDTH-1:0]           resolve_target,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       update_predictor,
    output logic [WIDTH-1:0]           pc_to_update,
    output logic [WIDTH-1:0]           update_addr,
    output logic                       branch_result,
    output logic                       mispredict,
    output logic [WIDTH-1:0]           correct_pc
`ifdef BPRED_STATS_EN
    ,
    output logic [31:0]                stat_branches,
    output logic [31:0]                stat_mispredicts
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] pc_q     [DEPTH];
    logic [WIDTH-1:0] pc_d     [DEPTH];
    logic [WIDTH-1:0] target_q [DEPTH];
    logic [WIDTH-1:0] target_d [DEPTH];
    logic [DEPTH-1:0] taken_q, taken_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             update_q, update_d, mispredict_q, mispredict_d;
    logic             branch_result_q, branch_result_d;
    logic [WIDTH-1:0] pc_to_update_q, pc_to_update_d;
    logic [WIDTH-1:0] update_addr_q, update_addr_d;
    logic [WIDTH-1:0] correct_pc_q, correct_pc_d;
    logic             do_push, do_resolve, wrong;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    always_comb begin
        pc_d            = pc_q;
        target_d        = target_q;
        taken_d         = taken_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;
        pc_to_update_d  = pc_to_update_q;
        update_addr_d   = update_addr_q;
        branch_result_d = branch_result_q;
        correct_pc_d    = correct_pc_q;

        do_resolve = resolve && !empty;
        // A full FIFO can still accept a push when the oldest entry leaves this cycle.
        do_push    = push && !flush && (!full || do_resolve);
        wrong      = (taken_q[rd_ptr_q] != resolve_taken) ||
                     (taken_q[rd_ptr_q] && resolve_taken &&
                      (target_q[rd_ptr_q] != resolve_target));
        update_d     = do_resolve;
        mispredict_d = do_resolve && wrong;

        if (do_push) begin
            pc_d[wr_ptr_q]     = push_pc;
            target_d[wr_ptr_q] = push_target;
            taken_d[wr_ptr_q]  = push_taken;
            wr_ptr_d           = wr_ptr_q + PW'(1);
        end

        if (do_resolve) begin
            rd_ptr_d        = rd_ptr_q + PW'(1);
            pc_to_update_d  = pc_q[rd_ptr_q];
            update_addr_d   = resolve_target;
            branch_result_d = resolve_taken;
            correct_pc_d    = resolve_taken ? resolve_target : pc_q[rd_ptr_q] + WIDTH'(4);
        end

        if (do_push && !do_resolve)
            count_d = count_q + CW'(1);
        else if (!do_push && do_resolve)
            count_d = count_q - CW'(1);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]     <= '0;
                target_q[i] <= '0;
            end
            taken_q         <= '0;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            update_q        <= 1'b0;
            mispredict_q    <= 1'b0;
            branch_result_q <= 1'b0;
            pc_to_update_q  <= '0;
            update_addr_q   <= '0;
            correct_pc_q    <= '0;
        end else begin
            pc_q            <= pc_d;
            target_q        <= target_d;
            taken_q         <= taken_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            update_q        <= update_d;
            mispredict_q    <= mispredict_d;
            branch_result_q <= branch_result_d;
            pc_to_update_q  <= pc_to_update_d;
            update_addr_q   <= update_addr_d;
            correct_pc_q    <= correct_pc_d;
        end
    end

    assign count            = count_q;
    assign update_predictor = update_q;
    assign mispredict       = mispredict_q;
    assign branch_result    = branch_result_q;
    assign pc_to_update     = pc_to_update_q;
    assign update_addr      = update_addr_q;
    assign correct_pc       = correct_pc_q;

`ifdef BPRED_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

    // Counters advance on the edge that raises the matching pulse, saturating at all-ones.
    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (update_d && (stat_branches_q != 32'hFFFF_FFFF))
            stat_branches_d = stat_branches_q + 32'd1;
        if (mispredict_d && (stat_mispredicts_q != 32'hFFFF_FFFF))
            stat_mispredicts_d = stat_mispredicts_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_pred_tracker.sv
// Directed self-checking bench for branch_pred_tracker (DEPTH=4, WIDTH=32).
module tb_branch_pred_tracker;

    logic        CLK, nRST;
    logic        push, push_taken, resolve, resolve_taken, flush;
    logic [31:0] push_pc, push_target, resolve_target;
    logic        full, empty, update_predictor, branch_result, mispredict;
    logic [2:0]  count;
    logic [31:0] pc_to_update, update_addr, correct_pc;
`ifdef BPRED_STATS_EN
    logic [31:0] stat_branches, stat_mispredicts;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    branch_pred_tracker #(.DEPTH(4), .WIDTH(32)) dut (
        .CLK(CLK), .nRST(nRST),
        .push(push), .push_pc(push_pc), .push_target(push_target), .push_taken(push_taken),
        .resolve(resolve), .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .flush(flush), .full(full), .empty(empty), .count(count),
        .update_predictor(update_predictor), .pc_to_update(pc_to_update),
        .update_addr(update_addr), .branch_result(branch_result),
        .mispredict(mispredict), .correct_pc(correct_pc)
`ifdef BPRED_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Apply one cycle of stimulus, then return 1ns after the rising edge.
    task automatic cyc(input logic p, input logic [31:0] ppc, input logic pt,
                       input logic [31:0] ptgt, input logic r, input logic rt,
                       input logic [31:0] rtgt, input logic f);
        push = p; push_pc = ppc; push_taken = pt; push_target = ptgt;
        resolve = r; resolve_taken = rt; resolve_target = rtgt; flush = f;
        @(posedge CLK);
        #1;
        push = 1'b0; resolve = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        push = 0; push_pc = 0; push_taken = 0; push_target = 0;
        resolve = 0; resolve_taken = 0; resolve_target = 0; flush = 0;
        #3;
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b exp 1", empty); end
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b exp 0", full); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_cmp++; if (update_predictor !== 1'b0) begin n_fail++; $display("FAIL reset_update got %b exp 0", update_predictor); end
        n_cmp++; if (correct_pc !== 32'h0) begin n_fail++; $display("FAIL reset_correct_pc got %h exp 0", correct_pc); end
        @(posedge CLK);
        #1;
        nRST = 1'b1;
    endtask

    task automatic test_basic();
        cyc(1, 32'h100, 0, 32'h0, 0, 0, 32'h0, 0);
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL basic_count got %0d exp 1", count); end
        n_cmp++; if (update_predictor !== 1'b0) begin n_fail++; $display("FAIL basic_no_pulse got %b exp 0", update_predictor); end
        cyc(0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0);
        n_cmp++; if (update_predictor !== 1'b1) begin n_fail++; $display("FAIL basic_update got %b exp 1", update_predictor); end
        n_cmp++; if (pc_to_update !== 32'h100) begin n_fail++; $display("FAIL basic_pc got %h exp 100", pc_to_update); end
        n_cmp++; if (branch_result !== 1'b0) begin n_fail++; $display("FAIL basic_result got %b exp 0", branch_result); end
        n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL basic_mispredict got %b exp 0", mispredict); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty got %b exp 1", empty); end
        cyc(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
        n_cmp++; if (update_predictor !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_end got %b exp 0", update_predictor); end
        n_cmp++; if (pc_to_update !== 32'h100) begin n_fail++; $display("FAIL basic_pc_hold got %h exp 100", pc_to_update); end
    endtask

    task automatic test_mispredict();
        cyc(1, 32'h200, 1, 32'h300, 0, 0, 32'h0, 0);
        cyc(0, 32'h0, 0, 32'h0, 1, 1, 32'h340, 0);
        n_cmp++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL mp_target got %b exp 1", mispredict); end
        n_cmp++; if (correct_pc !== 32'h340) begin n_fail++; $display("FAIL mp_target_cpc got %h exp 340", correct_pc); end
        n_cmp++; if (update_addr !== 32'h340) begin n_fail++; $display("FAIL mp_update_addr got %h exp 340", update_addr); end
        cyc(1, 32'h200, 1, 32'h300, 0, 0, 32'h0, 0);
        cyc(0, 32'h0, 0, 32'h0, 1, 0, 32'h999, 0);
        n_cmp++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL mp_dir got %b exp 1", mispredict); end
        n_cmp++; if (correct_pc !== 32'h204) begin n_fail++; $display("FAIL mp_dir_cpc got %h exp 204", correct_pc); end
        n_cmp++; if (branch_result !== 1'b0) begin n_fail++; $display("FAIL mp_dir_result got %b exp 0", branch_result); end
        cyc(1, 32'h400, 1, 32'h500, 0, 0, 32'h0, 0);
        cyc(0, 32'h0, 0, 32'h0, 1, 1, 32'h500, 0);
        n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL mp_correct_taken got %b exp 0", mispredict); end
        n_cmp++; if (branch_result !== 1'b1) begin n_fail++; $display("FAIL mp_taken_result got %b exp 1", branch_result); end
        cyc(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
        n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL mp_pulse_end got %b exp 0", mispredict); end
        cyc(1, 32'hFFFF_FFFC, 1, 32'h80, 0, 0, 32'h0, 0);
        cyc(0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0);
        n_cmp++; if (correct_pc !== 32'h0) begin n_fail++; $display("FAIL mp_wrap_cpc got %h exp 0", correct_pc); end
    endtask

    task automatic test_full();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'h20; exp_pc[1] = 32'h30; exp_pc[2] = 32'h40; exp_pc[3] = 32'h60;
        cyc(1, 32'h10, 0, 32'h0, 0, 0, 32'h0, 0);
        cyc(1, 32'h20, 0, 32'h0, 0, 0, 32'h0, 0);
        cyc(1, 32'h30, 0, 32'h0, 0, 0, 32'h0, 0);
        n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL full_at3 got %b exp 0", full); end
        cyc(1, 32'h40, 0, 32'h0, 0, 0, 32'h0, 0);
        n_cmp++; if (full !== 1'b1) begin n_fail++; $display("FAIL full_at4 got %b exp 1", full); end
        cyc(1, 32'h50, 0, 32'h0, 0, 0, 32'h0, 0);
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_drop_count got %0d exp 4", count); end
        cyc(1, 32'h60, 0, 32'h0, 1, 0, 32'h0, 0);
        n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_pr_count got %0d exp 4", count); end
        n_cmp++; if (pc_to_update !== 32'h10) begin n_fail++; $display("FAIL full_pr_pc got %h exp 10", pc_to_update); end
        n_cmp++; if (update_predictor !== 1'b1) begin n_fail++; $display("FAIL full_pr_update got %b exp 1", update_predictor); end
        for (int i = 0; i < 4; i++) begin
            cyc(0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0);
            n_cmp++;
            if (pc_to_update !== exp_pc[i]) begin
                n_fail++; $display("FAIL full_drain_%0d got %h exp %h", i, pc_to_update, exp_pc[i]);
            end
        end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL full_drained_empty got %b exp 1", empty); end
    endtask

    task automatic test_empty_resolve();
        cyc(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
        cyc(0, 32'h0, 0, 32'h0, 1, 1, 32'h55, 0);
        n_cmp++; if (update_predictor !== 1'b0) begin n_fail++; $display("FAIL empty_res_update got %b exp 0", update_predictor); end
        n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL empty_res_mp got %b exp 0", mispredict); end
        cyc(1, 32'h700, 0, 32'h0, 1, 1, 32'h55, 0);
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL empty_pr_count got %0d exp 1", count); end
        n_cmp++; if (update_predictor !== 1'b0) begin n_fail++; $display("FAIL empty_pr_update got %b exp 0", update_predictor); end
        cyc(0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0);
        n_cmp++; if (pc_to_update !== 32'h700) begin n_fail++; $display("FAIL empty_pr_pc got %h exp 700", pc_to_update); end
    endtask

    task automatic test_flush();
        cyc(1, 32'h800, 1, 32'h880, 0, 0, 32'h0, 0);
        cyc(1, 32'h900, 0, 32'h0, 0, 0, 32'h0, 0);
        cyc(1, 32'hA00, 0, 32'h0, 0, 0, 32'h0, 0);
        cyc(1, 32'hB00, 0, 32'h0, 1, 1, 32'h880, 1);
        n_cmp++; if (update_predictor !== 1'b1) begin n_fail++; $display("FAIL flush_update got %b exp 1", update_predictor); end
        n_cmp++; if (pc_to_update !== 32'h800) begin n_fail++; $display("FAIL flush_pc got %h exp 800", pc_to_update); end
        n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL flush_mp got %b exp 0", mispredict); end
        n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", count); end
        cyc(0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0);
        n_cmp++; if (update_predictor !== 1'b0) begin n_fail++; $display("FAIL flush_after_update got %b exp 0", update_predictor); end
    endtask

    task automatic test_reset_mid();
        cyc(1, 32'hC00, 1, 32'hD00, 0, 0, 32'h0, 0);
        cyc(1, 32'hC10, 0, 32'h0, 0, 0, 32'h0, 0);
        cyc(0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0);
        n_cmp++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL rst_pre_mp got %b exp 1", mispredict); end
        nRST = 1'b0;
        #1;
        n_cmp++; if (update_predictor !== 1'b0) begin n_fail++; $display("FAIL rst_mid_update got %b exp 0", update_predictor); end
        n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mp got %b exp 0", mispredict); end
        n_cmp++; if (pc_to_update !== 32'h0) begin n_fail++; $display("FAIL rst_mid_pc got %h exp 0", pc_to_update); end
        n_cmp++; if (correct_pc !== 32'h0) begin n_fail++; $display("FAIL rst_mid_cpc got %h exp 0", correct_pc); end
        n_cmp++; if (update_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mid_addr got %h exp 0", update_addr); end
        n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_mid_empty got %b exp 1", empty); end
        #1;
        nRST = 1'b1;
        cyc(1, 32'hE00, 0, 32'h0, 1, 0, 32'h0, 0);
        n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL rst_after_count got %0d exp 1", count); end
        n_cmp++; if (update_predictor !== 1'b0) begin n_fail++; $display("FAIL rst_after_update got %b exp 0", update_predictor); end
    endtask

`ifdef BPRED_STATS_EN
    task automatic test_stats();
        nRST = 1'b0;
        #1;
        n_cmp++; if (stat_branches !== 32'd0) begin n_fail++; $display("FAIL stat_rst got %0d exp 0", stat_branches); end
        nRST = 1'b1;
        cyc(1, 32'h10, 0, 32'h0, 0, 0, 32'h0, 0);
        cyc(1, 32'h20, 0, 32'h0, 0, 0, 32'h0, 0);
        cyc(1, 32'h30, 1, 32'h50, 0, 0, 32'h0, 0);
        cyc(0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0);
        cyc(0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0);
        cyc(0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 0);
        cyc(0, 32'h0, 0, 32'h0, 0, 0, 32'h0, 0);
        n_cmp++; if (stat_branches !== 32'd3) begin n_fail++; $display("FAIL stat_branches got %0d exp 3", stat_branches); end
        n_cmp++; if (stat_mispredicts !== 32'd1) begin n_fail++; $display("FAIL stat_mispredicts got %0d exp 1", stat_mispredicts); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_mispredict();
        test_full();
        test_empty_resolve();
        test_flush();
        test_reset_mid();
`ifdef BPRED_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_pred_tracker.md
BRANCH_PRED_TRACKER -- requirements
Module: branch_pred_tracker

Interface
REQ-001: Parameter DEPTH, default 4; number of in-flight prediction entries; power of two, at least 2.
REQ-002: Parameter WIDTH, default 32; address width in bits.
REQ-003: CLK  input  1  system clock; all state updates on the rising edge.
REQ-004: nRST  input  1  reset, asynchronous, active-low.
REQ-005: push  input  1  fetch issued a prediction this cycle.
REQ-006: push_pc / push_target  input  WIDTH each  PC of the predicted instruction / predicted target.
REQ-007: push_taken  input  1  predicted direction.
REQ-008: resolve  input  1  execute resolved the oldest branch or jump this cycle.
REQ-009: resolve_taken / resolve_target  input  1 / WIDTH  actual direction / actual target.
REQ-010: flush  input  1  pipeline flush; discard all in-flight entries.
REQ-011: full / empty  output  1 each  FIFO status.
REQ-012: count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-013: update_predictor  output  1  one-cycle pulse to the predictor update port.
REQ-014: pc_to_update / update_addr  output  WIDTH each  PC to train / resolved target.
REQ-015: branch_result  output  1  resolved direction.
REQ-016: mispredict  output  1  one-cycle pulse; prediction was wrong.
REQ-017: correct_pc  output  WIDTH  redirect PC, valid while mispredict is high.

Function
REQ-018: The block SHALL be a circular FIFO of DEPTH entries {pc, taken, target}, with read/write pointers wrapping modulo DEPTH.
REQ-019: push while not full SHALL write the entry at the write pointer; push while full without a same-cycle accepted resolve SHALL be dropped, with no state change.
REQ-020: push and resolve in the same cycle on a full FIFO SHALL both be accepted; count stays DEPTH.
REQ-021: push and resolve in the same cycle on an empty FIFO SHALL accept the push only; the resolve is ignored.
REQ-022: resolve while not empty SHALL pop the oldest entry and, on the next cycle only, assert update_predictor with pc_to_update equal to the entry pc, branch_result equal to resolve_taken, and update_addr equal to resolve_target (one-cycle registered latency).
REQ-023: resolve while empty SHALL be ignored; no pulse is generated.
REQ-024: mispredict SHALL pulse together with update_predictor when (entry.taken != resolve_taken) or (both taken and entry.target != resolve_target).
REQ-025: correct_pc SHALL be resolve_target if resolve_taken, else entry.pc + 4 truncated to WIDTH bits (wraps at 2^WIDTH).
REQ-026: flush SHALL empty the FIFO on that edge; a same-cycle resolve SHALL still be processed and produce its update/mispredict pulse; a same-cycle push SHALL be dropped.
REQ-027: full SHALL equal (count == DEPTH) and empty SHALL equal (count == 0), both combinational from count.
REQ-028: Outside pulse cycles, update_predictor and mispredict SHALL be 0; pc_to_update, update_addr, branch_result and correct_pc SHALL hold their last values.

Reset
REQ-029: Asserting nRST low SHALL asynchronously clear pointers, count, all entries, update_predictor, mispredict, branch_result, pc_to_update, update_addr and correct_pc to 0; empty=1 and full=0.
REQ-030: Reset asserted mid-operation SHALL discard all entries and any pending pulse; the first edge after release SHALL behave as a push/resolve on an empty FIFO.

Configuration
REQ-031: With BPRED_STATS_EN defined, the block SHALL add outputs stat_branches and stat_mispredicts, 32 bits each, incremented on every update_predictor pulse and every mispredict pulse respectively, saturating at 0xFFFFFFFF and cleared by reset.
REQ-032: Without BPRED_STATS_EN, these ports and counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-033: Reset, then push pc=0x100 taken=0 target=0x0; resolve taken=0 -> next cycle update_predictor=1, pc_to_update=0x100, branch_result=0, mispredict=0, empty=1.
REQ-034: Push pc=0x200 taken=1 target=0x300; resolve taken=1 target=0x340 -> mispredict=1, correct_pc=0x340; a second scenario with resolve taken=0 -> correct_pc=0x204.
REQ-035: Push 5 entries with DEPTH=4 -> full=1 after 4, 5th dropped; then push+resolve in the same cycle -> count stays 4, and the resolved pc is the 1st pushed.
REQ-036: Resolve on empty -> no pulse; push+resolve same cycle on empty -> count=1, no pulse.
REQ-037: 3 entries, flush+resolve+push same cycle -> update pulse for the oldest entry, count=0 next cycle; nRST pulsed mid-stream -> all outputs 0, empty=1.
REQ-038: With BPRED_STATS_EN, 3 resolves including 1 mispredict -> stat_branches=3, stat_mispredicts=1.
